// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing, types and latency helper for the issue-side hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam int NREG     = 8;
  localparam int ADDR_W   = $clog2(NREG);
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [1:0]       rdy;
  } sb_entry_t;

  // rdy holds the number of cycles after the next one in which a consumer must still wait.
  // An ALU result is therefore forwardable to the very next instruction.
  function automatic logic [1:0] lat_to_rdy(input logic is_load);
    return is_load ? 2'(LOAD_LAT - 1) : 2'(ALU_LAT - 1);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's outstanding-write count and forwarding countdown.
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      set,
  input  logic      set_load,
  input  logic      dec,
  input  logic      clear,
  output sb_entry_t entry
);
  sb_entry_t q, d;
  logic      dec_ok;

  assign dec_ok = dec && (q.cnt != '0);

  always_comb begin
    d = q;
    if (q.rdy != '0) d.rdy = q.rdy - 2'd1;
    if (clear) begin
      d = '0;
    end else if (set) begin
      // The youngest write owns the countdown; a matching writeback cancels the increment.
      d.rdy = lat_to_rdy(set_load);
      if (!dec_ok && (q.cnt != '1)) d.cnt = q.cnt + 1'b1;
    end else if (dec_ok) begin
      d.cnt = q.cnt - 1'b1;
      if (q.cnt == CNT_W'(1)) d.rdy = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q <= '0;
    else         q <= d;
  end

  assign entry = q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side RAW hazard scoreboard: stalls decode on sources whose producer is not yet forwardable.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic              issue_rd_we_i,
  input  logic              issue_is_load_i,
  input  logic [ADDR_W-1:0] issue_rd_addr_i,
  input  logic [ADDR_W-1:0] issue_rs1_addr_i,
  input  logic [ADDR_W-1:0] issue_rs2_addr_i,
  input  logic              issue_use_rs1_i,
  input  logic              issue_use_rs2_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_rd_addr_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              issue_fire_o,
  output logic [NREG-1:0]   pending_o,
  output logic              overflow_o
);
  sb_entry_t entries [NREG];
  logic      h1, h2;
  logic      issue_we, wb_we, overflow_set;

  assign entries[0] = '0;

  assign h1 = issue_use_rs1_i && (issue_rs1_addr_i != '0) &&
              (entries[issue_rs1_addr_i].cnt != '0) && (entries[issue_rs1_addr_i].rdy != '0);
  assign h2 = issue_use_rs2_i && (issue_rs2_addr_i != '0) &&
              (entries[issue_rs2_addr_i].cnt != '0) && (entries[issue_rs2_addr_i].rdy != '0);

  assign stall_o      = issue_valid_i && (h1 || h2) && !flush_i;
  // Nothing issues while reset is held or while the pipeline is being flushed.
  assign issue_fire_o = issue_valid_i && rst_ni && !stall_o && !flush_i;

  assign issue_we = issue_fire_o && issue_rd_we_i && (issue_rd_addr_i != '0);
  assign wb_we    = wb_valid_i && (wb_rd_addr_i != '0) && !flush_i;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_entry
      sb_entry u_entry (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set      (issue_we && (issue_rd_addr_i == reg_addr_t'(r))),
        .set_load (issue_is_load_i),
        .dec      (wb_we && (wb_rd_addr_i == reg_addr_t'(r))),
        .clear    (flush_i),
        .entry    (entries[r])
      );
      assign pending_o[r] = (entries[r].cnt != '0);
    end
  endgenerate

  assign pending_o[0] = 1'b0;

  assign overflow_set = issue_we && (entries[issue_rd_addr_i].cnt == '1) &&
                        !(wb_we && (wb_rd_addr_i == issue_rd_addr_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           overflow_o <= 1'b0;
    else if (overflow_set) overflow_o <= 1'b1;
  end
endmodule
